width_change_24to16: RTL and testbench
======================================

# width_change_24to16

Byte-stream width converter: 24-bit beats (three QUAN_BITS bytes, e.g. {b,g,r} pixels) in, 16-bit beats (two bytes) out, byte order preserved. It is the inverse of the 16→24 packing path and sits on the write-back side, returning 24-bit pixel/activation data to the 16-bit RAM/DMA word stream. A 6-byte internal buffer gives full output throughput with valid/ready flow control on both sides. An end-of-stream marker pads a stranded odd byte.

## Interface
- QUAN_BITS, 8, bits per byte lane (from hyper_para)
- s_clk  in  1  clock, all logic on rising edge
- s_rst_n  in  1  asynchronous reset, active-low
- bytes_in  in  3*QUAN_BITS  input beat {B2,B1,B0}; B0 (LSB lane) is the earliest byte
- bytes_valid  in  1  input beat valid
- bytes_last  in  1  qualifies the final beat of a stream; sampled with bytes_valid
- bytes_ready  out  1  input accepted when bytes_valid && bytes_ready
- o_bytes_out  out  2*QUAN_BITS  output word {second byte, first byte}
- o_bytes_valid  out  1  output word valid
- o_bytes_last  out  1  word carries the stream's final byte
- i_bytes_ready  in  1  downstream accepts when o_bytes_valid && i_bytes_ready

## Operation
- Buffer: 6 byte slots, slot 0 oldest; byte count cnt ∈ 0..6 (3-bit). Vacated slots are cleared to 0.
- push = bytes_valid && bytes_ready; pop = o_bytes_valid && i_bytes_ready.
- bytes_ready = (cnt <= 3) && !last_pend. It depends only on registered state and is never combinational on i_bytes_ready.
- o_bytes_valid = (cnt >= 2) || (cnt == 1 && last_pend).
- o_bytes_out = {slot1, slot0}. When cnt == 1 with last_pend, slot1 reads 0 (pad).
- Per cycle: remove 2 bytes on pop (1 byte in the pad case), shift the remainder down, then append B0,B1,B2 at positions cnt_after_pop..+2 on push. Next cnt = cnt − popped + 3·push.
- Push and pop in the same cycle are legal at any cnt that permits each; overflow is impossible because ready requires cnt ≤ 3.
- Last handling:
  - When a beat with bytes_last is accepted, last_pend sets and end_pos = total byte count after that push.
  - o_bytes_last = last_pend && (cnt ≤ 2), i.e. the word holds the final byte.
  - Popping that word clears last_pend and reopens bytes_ready.
  - An even total ends cleanly. An odd total emits a final word {0, Bfinal}.
- While last_pend is set, no new beat is accepted, so streams never mix.
- All outputs come from registered state: o_bytes_out, o_bytes_valid and o_bytes_last are stable while a word is held under backpressure.

## Timing
- Reset (async assert, sync-style deassert on the next edge):
  - cnt = 0, buffer = 0, last_pend = 0.
  - o_bytes_out = 0, o_bytes_valid = 0, o_bytes_last = 0.
  - bytes_ready = 0 while s_rst_n = 0, and 1 on the first cycle after release.
- Latency: a beat accepted on edge N yields its first word with o_bytes_valid high after edge N (one cycle).
- Steady state, downstream always ready: cnt cycles 3→4→2→3→4→2, one word out every cycle, input accepted 2 of every 3 cycles (6 bytes per 3 words, no bubbles).
- Backpressure (i_bytes_ready = 0): output is held, cnt stops decreasing, and bytes_ready drops once cnt ≥ 4.
- Reset mid-stream discards buffered bytes and the pending last; there is no partial word on the output after reset.

## Test plan
- Reset and one beat:
  - Hold s_rst_n = 0 → all outputs 0, bytes_ready = 0.
  - Release, push 0x030201 → next cycle o_bytes_out = 0x0201, valid.
  - Pop → cnt = 1, o_bytes_valid = 0.
- Even stream, i_bytes_ready = 1: push 0x030201, 0x060504 (last) → words 0x0201, 0x0403, 0x0605, last only on 0x0605. bytes_ready returns to 1 after that pop.
- Odd pad: push 0x030201 (last) → words 0x0201, then 0x0003 with o_bytes_last = 1, then cnt = 0.
- Throughput: continuous bytes_valid with incrementing bytes, i_bytes_ready = 1 → o_bytes_valid high every cycle after the first, bytes_ready pattern 1,1,0 repeating, output bytes strictly incrementing.
- Backpressure: i_bytes_ready random 50% → no byte lost, duplicated or reordered against a scoreboard; bytes_ready never high when cnt > 3; o_bytes_out stable while valid && !ready.
- Reset mid-operation: assert s_rst_n = 0 with cnt = 4 and last_pend = 1 → outputs 0 immediately. After release, a new stream 0x0C0B0A emits 0x0B0A first.

Source files
------------

// File: rtl/width_change_24to16.sv
// ---------------------------------------------------------------------------
// width_change_24to16
//
// Byte-stream width converter on the write-back path: accepts 24-bit beats
// (three QUAN_BITS-wide bytes, B0 in the LSB lane is the earliest byte) and
// emits 16-bit words (two bytes, first byte in the LSB lane). Byte order is
// preserved end to end. A six-byte buffer lets the output run at one word
// per cycle while the input is accepted two cycles out of three.
//
// End of stream: a beat carrying bytes_last arms a pending-last flag. Input
// is then blocked until the word holding the final byte has been popped.
// If the stream has an odd byte count, that final word is padded with a zero
// upper byte.
//
// Ports
//   s_clk          in   clock, all logic on the rising edge
//   s_rst_n        in   asynchronous active-low reset
//   bytes_in       in   input beat {B2,B1,B0}
//   bytes_valid    in   input beat valid
//   bytes_last     in   input beat is the final beat of its stream
//   bytes_ready    out  input beat accepted when bytes_valid && bytes_ready
//   o_bytes_out    out  output word {second byte, first byte}
//   o_bytes_valid  out  output word valid
//   o_bytes_last   out  output word carries the stream's final byte
//   i_bytes_ready  in   downstream accepts when o_bytes_valid && i_bytes_ready
// ---------------------------------------------------------------------------
module width_change_24to16 #(
  parameter int QUAN_BITS = 8
) (
  input  logic                   s_clk,
  input  logic                   s_rst_n,
  input  logic [3*QUAN_BITS-1:0] bytes_in,
  input  logic                   bytes_valid,
  input  logic                   bytes_last,
  output logic                   bytes_ready,
  output logic [2*QUAN_BITS-1:0] o_bytes_out,
  output logic                   o_bytes_valid,
  output logic                   o_bytes_last,
  input  logic                   i_bytes_ready
);

  localparam int W = QUAN_BITS;

  // Six byte slots packed LSB-first: slot 0 (oldest) sits in r_buf[W-1:0].
  // Unused slots are always zero, so a new beat can be OR-ed into place.
  logic [6*W-1:0] r_buf;
  logic [2:0]     r_cnt;        // bytes held, 0..6
  logic           r_last_pend;  // final beat of the stream is in the buffer
  logic           r_rst_done;   // keeps bytes_ready low until after reset

  logic           w_push;
  logic           w_pop;
  logic [2:0]     w_pop_n;      // bytes removed this cycle
  logic [2:0]     w_cnt_mid;    // count after the pop, before the push
  logic [2:0]     w_cnt_nxt;
  logic [6*W-1:0] w_buf_nxt;
  logic [6*W-1:0] w_beat_ext;
  logic           w_last_nxt;
  logic [W-1:0]   w_slot1;

  // Every output is a function of registered state only, so nothing here is
  // combinational on i_bytes_ready or bytes_valid.
  assign bytes_ready   = r_rst_done && (r_cnt <= 3'd3) && !r_last_pend;
  assign o_bytes_valid = (r_cnt >= 3'd2) || ((r_cnt == 3'd1) && r_last_pend);
  assign o_bytes_last  = r_last_pend && (r_cnt <= 3'd2);

  // With a single stranded byte the upper lane is the zero pad.
  assign w_slot1     = (r_cnt == 3'd1) ? '0 : r_buf[2*W-1:W];
  assign o_bytes_out = {w_slot1, r_buf[W-1:0]};

  assign w_push     = bytes_valid && bytes_ready;
  assign w_pop      = o_bytes_valid && i_bytes_ready;
  assign w_beat_ext = {{(3*W){1'b0}}, bytes_in};

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_pop_n    = 3'd0;
    w_buf_nxt  = '0;
    w_last_nxt = r_last_pend;

    if (w_pop) begin
      w_pop_n = (r_cnt == 3'd1) ? 3'd1 : 3'd2;
    end
    w_cnt_mid = r_cnt - w_pop_n;

    // Drop popped bytes; zeros shift in at the top, clearing vacated slots.
    w_buf_nxt = r_buf >> (W * int'(w_pop_n));

    // Append the beat right after the surviving bytes. Ready requires
    // cnt <= 3, so the three new bytes always fit in the six slots.
    if (w_push) begin
      w_buf_nxt = w_buf_nxt | (w_beat_ext << (W * int'(w_cnt_mid)));
    end
    w_cnt_nxt = w_cnt_mid + (w_push ? 3'd3 : 3'd0);

    // Setting and clearing are exclusive: a push needs !r_last_pend and
    // popping the final word needs r_last_pend.
    if (w_push && bytes_last) begin
      w_last_nxt = 1'b1;
    end else if (w_pop && o_bytes_last) begin
      w_last_nxt = 1'b0;
    end
  end

  // NOTE: the buffer is reset along with the control state so no stale
  // bytes can surface as a partial word after a mid-stream reset.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_buf       <= '0;
      r_cnt       <= 3'd0;
      r_last_pend <= 1'b0;
      r_rst_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      r_buf       <= w_buf_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_pend <= w_last_nxt;
      r_rst_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_width_change_24to16.sv
// ---------------------------------------------------------------------------
// tb_width_change_24to16
//
// Directed bench for width_change_24to16. A byte-level model turns every
// accepted beat into expected output words (pushed to a scoreboard queue)
// and tracks the expected buffer fill and pending-last flag, from which the
// expected bytes_ready / o_bytes_valid / o_bytes_last are derived. Each cycle
// the bench samples on the falling edge, compares the held word against the
// head of the scoreboard and pops it when the downstream handshake fires.
// ---------------------------------------------------------------------------
module tb_width_change_24to16;

  logic        s_clk = 1'b0;
  logic        s_rst_n;
  logic [23:0] bytes_in;
  logic        bytes_valid;
  logic        bytes_last;
  logic        bytes_ready;
  logic [15:0] o_bytes_out;
  logic        o_bytes_valid;
  logic        o_bytes_last;
  logic        i_bytes_ready;

  always #5 s_clk = ~s_clk;

  width_change_24to16 #(.QUAN_BITS(8)) dut (
    .s_clk         (s_clk),
    .s_rst_n       (s_rst_n),
    .bytes_in      (bytes_in),
    .bytes_valid   (bytes_valid),
    .bytes_last    (bytes_last),
    .bytes_ready   (bytes_ready),
    .o_bytes_out   (o_bytes_out),
    .o_bytes_valid (o_bytes_valid),
    .o_bytes_last  (o_bytes_last),
    .i_bytes_ready (i_bytes_ready)
  );

  typedef struct {
    logic [15:0] word;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pend_q[$];
  int         n_cmp  = 0;
  int         n_err  = 0;
  int         mcnt   = 0;
  bit         mlast  = 1'b0;
  bit         rst_ok = 1'b0;
  bit         g_push = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    mcnt   = 0;
    mlast  = 1'b0;
    rst_ok = 1'b0;
  endtask

  task automatic model_push(input logic [23:0] data, input logic last);
    word_t w;
    for (int b = 0; b < 3; b++) pend_q.push_back(data[8*b +: 8]);
    mcnt += 3;
    while (pend_q.size() >= 2) begin
      w.word = {pend_q[1], pend_q[0]};
      w.last = 1'b0;
      void'(pend_q.pop_front());
      void'(pend_q.pop_front());
      exp_q.push_back(w);
    end
    if (last) begin
      mlast = 1'b1;
      if (pend_q.size() == 1) begin
        w.word = {8'h00, pend_q.pop_front()};
        w.last = 1'b1;
        exp_q.push_back(w);
      end else begin
        w = exp_q.pop_back();
        w.last = 1'b1;
        exp_q.push_back(w);
      end
    end
  endtask

  // One clock cycle: check on the falling edge, update the model, then
  // return 1 time unit after the rising edge, ready for new stimulus.
  task automatic tick();
    bit    exp_valid, exp_ready, exp_last, do_pop;
    word_t w;
    @(negedge s_clk);
    exp_valid = (mcnt >= 2) || (mcnt == 1 && mlast);
    exp_ready = rst_ok && (mcnt <= 3) && !mlast;
    exp_last  = mlast && (mcnt <= 2);
    check("bytes_ready", 32'(bytes_ready), 32'(exp_ready));
    check("o_bytes_valid", 32'(o_bytes_valid), 32'(exp_valid));
    do_pop = exp_valid && i_bytes_ready;
    g_push = bytes_valid && exp_ready;
    if (exp_valid) begin
      check("o_bytes_last", 32'(o_bytes_last), 32'(exp_last));
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q[0];
        check("o_bytes_out", 32'(o_bytes_out), 32'(w.word));
        if (do_pop) void'(exp_q.pop_front());
      end
    end
    if (do_pop) begin
      mcnt -= (mcnt == 1) ? 1 : 2;
      if (exp_last) mlast = 1'b0;
    end
    if (g_push) model_push(bytes_in, bytes_last);
    @(posedge s_clk);
    #1;
    if (s_rst_n) rst_ok = 1'b1;
  endtask

  task automatic drive(input logic [23:0] data, input logic valid,
                       input logic last, input logic rdy);
    bytes_in      = data;
    bytes_valid   = valid;
    bytes_last    = last;
    i_bytes_ready = rdy;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive(24'h0, 1'b0, 1'b0, 1'b1);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},   32'(o_bytes_out),   32'h0);
    check({tag, "_valid"}, 32'(o_bytes_valid), 32'h0);
    check({tag, "_last"},  32'(o_bytes_last),  32'h0);
    check({tag, "_ready"}, 32'(bytes_ready),   32'h0);
  endtask

  task automatic reset_dut(input string tag);
    bytes_in      = '0;
    bytes_valid   = 1'b0;
    bytes_last    = 1'b0;
    i_bytes_ready = 1'b0;
    s_rst_n       = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    tick();
    s_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         idx;

    // Reset held, then one beat held under backpressure and popped.
    reset_dut("rst0");
    drive(24'h030201, 1'b1, 1'b0, 1'b0);
    check("one_word", 32'(o_bytes_out), 32'h0201);
    check("one_valid", 32'(o_bytes_valid), 32'h1);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    check("one_after_pop_valid", 32'(o_bytes_valid), 32'h0);

    // Even stream: last rides on the word with the sixth byte.
    reset_dut("rst1");
    drive(24'h030201, 1'b1, 1'b0, 1'b1);
    drive(24'h060504, 1'b1, 1'b1, 1'b1);
    drain("even_drain");
    check("even_ready_back", 32'(bytes_ready), 32'h1);

    // Odd stream: final word padded as {0, 0x03}.
    reset_dut("rst2");
    drive(24'h030201, 1'b1, 1'b1, 1'b1);
    drain("pad_drain");
    check("pad_ready_back", 32'(bytes_ready), 32'h1);

    // Throughput: source always valid, sink always ready.
    reset_dut("rst3");
    b = 8'h10;
    for (int k = 0; k < 12; k++) begin
      drive({b + 8'd2, b + 8'd1, b}, 1'b1, 1'b0, 1'b1);
      check("tput_push", 32'(g_push), 32'((k % 3) != 2));
      check("tput_valid", 32'(o_bytes_valid), 32'h1);
      if (g_push) b = b + 8'd3;
    end
    drain("tput_drain");

    // Random valid and backpressure; the scoreboard catches loss/reorder.
    reset_dut("rst4");
    idx = 0;
    for (int c = 0; c < 400 && idx < 10; c++) begin
      b = 8'(8'h40 + idx * 3);
      drive({b + 8'd2, b + 8'd1, b}, 1'($urandom_range(0, 1)), 1'(idx == 9),
            1'($urandom_range(0, 1)));
      if (g_push) idx++;
    end
    check("rand_all_sent", 32'(idx), 32'd10);
    drain("rand_drain");

    // Reset with four bytes buffered and a pending last.
    reset_dut("rst5");
    drive(24'h151413, 1'b1, 1'b0, 1'b0);
    drive(24'h181716, 1'b1, 1'b1, 1'b1);
    bytes_valid   = 1'b0;
    bytes_last    = 1'b0;
    i_bytes_ready = 1'b0;
    s_rst_n       = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    tick();
    tick();
    s_rst_n = 1'b1;
    tick();
    drive(24'h0C0B0A, 1'b1, 1'b1, 1'b0);
    check("midrst_first", 32'(o_bytes_out), 32'h0B0A);
    drain("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
